pll_reset_sequencer: RTL
========================

# pll_reset_sequencer

Reset and lock controller for a single-output fractional/integer PLL wrapper such as the 166 MHz camera/SDRAM clock generator. Holds the PLL in reset for a fixed interval, then waits for `locked` with a timeout and a bounded retry count. It requires lock to stay stable before releasing the downstream reset, and re-sequences automatically on loss of lock. It runs on the PLL reference clock, upstream of every PLL-clocked domain.

## Interface
Parameters:
- `RST_HOLD`, 16: cycles the PLL reset is held high per attempt (≥1).
- `LOCK_STABLE`, 256: consecutive synchronized-lock cycles required before release (≥1).
- `LOCK_TIMEOUT`, 50000: cycles allowed in WAIT_LOCK per attempt (≥1).
- `MAX_RETRY`, 3: retries after the first attempt before FAIL (total attempts = MAX_RETRY+1).
- `CNT_W`, 17: phase counter width; must hold max(RST_HOLD, LOCK_STABLE, LOCK_TIMEOUT)−1.

Ports:
- `refclk` in 1: reference clock (50 MHz); sole clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pll_locked` in 1: PLL lock, asynchronous to refclk.
- `restart` in 1: synchronous one-cycle request to restart sequencing.
- `pll_rst` out 1: to PLL `rst`, active-high.
- `ready` out 1: PLL locked and stable.
- `sys_rst_n` out 1: downstream reset, active-low.
- `error` out 1: retries exhausted.
- `state_o` out 3: current state encoding.
- `lock_loss_cnt` out 8: saturating count of lock losses while in RUN.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to produce `lock_s`. No other path uses the raw input.
- States and encodings: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4. A single phase counter `cnt` is cleared on every state entry.
- RESET: when `cnt==RST_HOLD-1`, go to WAIT_LOCK.
- WAIT_LOCK: if `lock_s`=1, go to STABLE. Otherwise, if `cnt==LOCK_TIMEOUT-1`:
  - if `attempt==MAX_RETRY`, go to FAIL;
  - else increment `attempt` and go to RESET.
- STABLE: if `lock_s`=0, go to WAIT_LOCK. The timeout restarts and `attempt` is unchanged. If `cnt==LOCK_STABLE-1` with `lock_s`=1, go to RUN and clear `attempt`.
- RUN: if `lock_s`=0, go to RESET and increment `lock_loss_cnt`, saturating at 255.
- FAIL: terminal. Left only via `restart` or `rst_n`.
- `restart`=1 has the highest priority in every state: go to RESET, clear `cnt` and `attempt`, and preserve `lock_loss_cnt`.
  - If `restart` and a loss of lock coincide in RUN, `restart` wins and `lock_loss_cnt` is not incremented.
- Outputs are Moore, decoded from registered state only:
  - `pll_rst` = RESET or FAIL
  - `ready` = RUN
  - `sys_rst_n` = RUN
  - `error` = FAIL
- Unreachable encodings 5–7 go to RESET on the next edge.

## Timing
- During and immediately after reset:
  - state RESET, `cnt`=0, `attempt`=0, sync flops 0, `lock_loss_cnt`=0
  - `pll_rst`=1, `ready`=0, `sys_rst_n`=0, `error`=0, `state_o`=0
- Each state phase lasts exactly its parameter in cycles: RESET = RST_HOLD, WAIT_LOCK timeout = LOCK_TIMEOUT.
- Lock-to-ready latency: `ready` rises on the (2+1+LOCK_STABLE)th refclk edge after `pll_locked` rises, provided the design is in WAIT_LOCK.
- Lock-loss response: `ready` and `sys_rst_n` fall 3 edges after `pll_locked` falls (2 sync + 1 state). `pll_rst` rises on that same edge.
- `restart` takes effect on the next edge; `pll_rst`=1 from that edge.
- Mid-operation `rst_n` assertion forces the reset values immediately, asynchronously.

## Test plan
Bench overrides: RST_HOLD=4, LOCK_STABLE=8, LOCK_TIMEOUT=32, MAX_RETRY=2.
- Release `rst_n`; raise `pll_locked` 10 cycles after `pll_rst` falls → `pll_rst` is high for exactly 4 cycles; `ready`/`sys_rst_n` rise 11 edges after `pll_locked`; `state_o`=3.
- Hold `pll_locked`=0 → 3 `pll_rst` pulses of 4 cycles, each followed by 32 WAIT_LOCK cycles. Then `error`=1, `pll_rst`=1 and `state_o`=4 from edge 108 onward, held indefinitely.
- In STABLE, drop `pll_locked` for 1 cycle at stable count 5 → return to WAIT_LOCK; `ready` rises 11 edges after lock returns; `pll_rst` never pulses.
- In RUN, drop `pll_locked` → `ready`=0 after 3 edges, `lock_loss_cnt`=1, and a full RESET/WAIT_LOCK/STABLE cycle follows. Repeat 300 times → `lock_loss_cnt` saturates at 255.
- In FAIL, pulse `restart` → state RESET on the next edge, `error`=0, `attempt` cleared. With lock present, `ready` returns.
- Assert `rst_n` mid-STABLE → all outputs take reset values without waiting for a clock edge; `lock_loss_cnt`=0.

Source files
------------

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer
//   Sequences a PLL out of reset: holds pll_rst for RST_HOLD cycles, waits up
//   to LOCK_TIMEOUT cycles for lock, then requires LOCK_STABLE consecutive
//   locked cycles before releasing the downstream reset. A lock timeout
//   retries MAX_RETRY times before parking in FAIL. Loss of lock while
//   running re-sequences from RESET and is counted (saturating).
// Ports
//   refclk        in   reference clock, sole clock
//   rst_n         in   async active-low reset
//   pll_locked    in   PLL lock, asynchronous to refclk
//   restart       in   one-cycle request to restart sequencing
//   pll_rst       out  PLL reset, active-high
//   ready         out  PLL locked and stable
//   sys_rst_n     out  downstream reset, active-low
//   error         out  retries exhausted
//   state_o       out  state encoding
//   lock_loss_cnt out  saturating count of lock losses while running
module pll_reset_sequencer #(
  parameter int RST_HOLD     = 16,
  parameter int LOCK_STABLE  = 256,
  parameter int LOCK_TIMEOUT = 50000,
  parameter int MAX_RETRY    = 3,
  parameter int CNT_W        = 17
) (
  input  logic       refclk,
  input  logic       rst_n,
  input  logic       pll_locked,
  input  logic       restart,
  output logic       pll_rst,
  output logic       ready,
  output logic       sys_rst_n,
  output logic       error,
  output logic [2:0] state_o,
  output logic [7:0] lock_loss_cnt
);

  localparam int AW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_RESET     = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [AW-1:0]    r_attempt;
  logic [1:0]       r_sync;
  logic [7:0]       r_llc;
  logic             w_lock_s;

  // Only the second synchronizer stage is ever looked at.
  assign w_lock_s = r_sync[1];

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_RESET;
      r_cnt     <= '0;
      r_attempt <= '0;
      r_sync    <= '0;
      r_llc     <= '0;
    end else begin
      r_sync <= {r_sync[0], pll_locked};
      if (restart) begin
        // Restart outranks everything, including a coincident lock loss.
        r_state   <= S_RESET;
        r_cnt     <= '0;
        r_attempt <= '0;
      end else begin
        case (r_state)
          S_RESET: begin
            if (r_cnt == CNT_W'(RST_HOLD - 1)) begin
              r_state <= S_WAIT_LOCK;
              r_cnt   <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_WAIT_LOCK: begin
            if (w_lock_s) begin
              r_state <= S_STABLE;
              r_cnt   <= '0;
            end else if (r_cnt == CNT_W'(LOCK_TIMEOUT - 1)) begin
              r_cnt <= '0;
              if (r_attempt == AW'(MAX_RETRY)) begin
                r_state <= S_FAIL;
              end else begin
                r_attempt <= r_attempt + 1'b1;
                r_state   <= S_RESET;
              end
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_STABLE: begin
            // A glitch sends us back to waiting with a fresh timeout; the
            // PLL is not reset again and the attempt count is kept.
            if (!w_lock_s) begin
              r_state <= S_WAIT_LOCK;
              r_cnt   <= '0;
            end else if (r_cnt == CNT_W'(LOCK_STABLE - 1)) begin
              r_state   <= S_RUN;
              r_cnt     <= '0;
              r_attempt <= '0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          S_RUN: begin
            r_cnt <= '0;
            if (!w_lock_s) begin
              r_state <= S_RESET;
              if (r_llc != 8'hFF) r_llc <= r_llc + 8'd1;
            end
          end
          S_FAIL: begin
            r_cnt <= '0;
          end
          default: begin
            r_state <= S_RESET;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Moore outputs straight from the state register.
  assign pll_rst       = (r_state == S_RESET) || (r_state == S_FAIL);
  assign ready         = (r_state == S_RUN);
  assign sys_rst_n     = (r_state == S_RUN);
  assign error         = (r_state == S_FAIL);
  assign state_o       = r_state;
  assign lock_loss_cnt = r_llc;

endmodule
